hazard_unit_mc: RTL and testbench
=================================

// Module: hazard_unit_mc
// PURPOSE
//  Hazard/forwarding controller for the 5-stage MIPS pipeline, successor to hazard_unit.
//  Adds a parametrised register-address width, a no-forwarding (stall-only) mode, an
//  interlock for a multi-cycle mult/div unit (HI/LO), and a saturating stall-cycle counter.
//  Sits beside the datapath; drives stall, flush and forward selects for stages F/D/E.
// PARAMETERS
//  REG_W   5  register address width; address 0 is hardwired zero and is never a hazard
//  MD_LAT  4  mult/div latency in cycles, >=2; HI/LO are valid MD_LAT cycles after start enters E
//  FWD_EN  1  1 = forwarding enabled; 0 = every RAW hazard on E/M resolved by stalling
//  CNT_W   16 width of StallCnt
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high
//  BranchD    in   1      branch instruction in D (compared in D)
//  MDUseD     in   1      D holds mult/div/mfhi/mflo (uses the multi-cycle unit)
//  RsD,RtD    in   REG_W  D-stage source registers
//  RsE,RtE    in   REG_W  E-stage source registers
//  MemtoRegE,RegWriteE,MDStartE in 1  E-stage load / regwrite / mult-div start
//  WriteRegE  in   REG_W  E-stage destination
//  MemtoRegM,RegWriteM in 1  M-stage load / regwrite
//  WriteRegM  in   REG_W  M-stage destination
//  RegWriteW  in   1      W-stage regwrite
//  WriteRegW  in   REG_W  W-stage destination
//  StallF,StallD out 1    hold PC / hold IF-ID register
//  FlushE     out  1      bubble into ID-EX register
//  ForwardAD,ForwardBD out 1  D-stage branch comparator select (1 = ALUOutM)
//  ForwardAE,ForwardBE out 2  E-stage ALU operand select: 00 regfile, 01 ResultW, 10 ALUOutM
//  MDBusy     out  1      multi-cycle unit busy (cnt != 0)
//  StallCnt   out  CNT_W  cycles with StallD=1 since reset, saturating
// BEHAVIOUR
//  match(a,b,we) = we & (a==b) & (a!=0).
//  Forwarding (FWD_EN=1), combinational: ForwardAE=10 if match(RsE,WriteRegM,RegWriteM),
//   else 01 if match(RsE,WriteRegW,RegWriteW), else 00; M has priority over W. BE same on RtE.
//   ForwardAD=match(RsD,WriteRegM,RegWriteM); ForwardBD same on RtD. FWD_EN=0: all forwards 0.
//  lwstall  = MemtoRegE & (match(RsD,RtE,1) | match(RtD,RtE,1)).
//  brstall  = BranchD & (match(RsD|RtD,WriteRegE,RegWriteE) | match(RsD|RtD,WriteRegM,MemtoRegM)).
//  rawstall (FWD_EN=0 only) = match(RsD|RtD, WriteRegE,RegWriteE) | match(RsD|RtD,WriteRegM,RegWriteM);
//   W excluded (regfile write-before-read).
//  mdstall  = MDUseD & (MDStartE | cnt!=0).
//  stall = lwstall|brstall|rawstall|mdstall; StallF=StallD=FlushE=stall.
//  MD counter cnt (width clog2(MD_LAT)): MDStartE -> cnt<=MD_LAT-1 (reload if already
//   busy; illegal in normal flow since start is itself MDUseD); else cnt!=0 -> cnt-1.
//   Consumer in D while start in E stalls exactly MD_LAT cycles. MDBusy = (cnt!=0).
//  StallCnt: +1 each clk with StallD=1; holds at 2^CNT_W-1 (no wrap).
//  Reset (async, any cycle incl. mid mult/div): cnt=0, StallCnt=0; while reset high outputs
//   StallF=StallD=0, FlushE=1, all forwards 0, MDBusy=0. Released counter resumes from 0.
//  All select/stall outputs are combinational from inputs and cnt; zero added latency.
// TESTING
//  1 RsE=6,WriteRegM=6,RegWriteM=1,WriteRegW=6,RegWriteW=1 -> ForwardAE=10; clear RegWriteM -> 01; RsE=0 -> 00.
//  2 MemtoRegE=1,RtE=6,RsD=6 -> StallF=StallD=FlushE=1, StallCnt+1/cycle; MemtoRegE=0 -> no stall.
//  3 BranchD=1,RegWriteE=1,WriteRegE=5,RsD=5 -> stall; then WriteRegM=5,MemtoRegM=1 -> stall; RegWriteM only -> ForwardAD=1, no stall.
//  4 MDStartE=1 one cycle with MDUseD=1 held -> stall exactly MD_LAT (4) cycles, MDBusy 3 cycles, then 0.
//  5 FWD_EN=0: RegWriteM=1,WriteRegM=7,RtD=7 -> stall, forwards 00; W-stage match alone -> no stall.
//  6 assert reset with cnt=2 and mid-stall -> cnt, StallCnt 0 immediately, FlushE=1; force stall 2^CNT_W+3 cycles -> StallCnt saturates.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding controller for the 5-stage MIPS pipeline.
// Resolves RAW hazards by forwarding into D and E, or by stalling when forwarding is
// disabled. Interlocks consumers of the multi-cycle mult/div unit until HI/LO are valid,
// and counts cycles spent stalled.
module hazard_unit_mc #(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned MD_LAT = 4,
    parameter int unsigned FWD_EN = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             BranchD,
    input  logic             MDUseD,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic             MemtoRegE,
    input  logic             RegWriteE,
    input  logic             MDStartE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic             MemtoRegM,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic             RegWriteW,
    input  logic [REG_W-1:0] WriteRegW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MDBusy,
    output logic [CNT_W-1:0] StallCnt
);

    localparam int unsigned MdCntW = (MD_LAT < 2) ? 1 : $clog2(MD_LAT);
    localparam logic [MdCntW-1:0] MdReload = MdCntW'(MD_LAT - 1);

    logic [MdCntW-1:0] md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic lwstall, brstall, rawstall, mdstall, stall;

    // Register 0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b,
                                   input logic we);
        return we && (a == b) && (a != '0);
    endfunction

    // Stall sources; rawstall only exists when forwarding cannot cover E/M producers.
    always_comb begin
        lwstall = MemtoRegE && (match(RsD, RtE, 1'b1) || match(RtD, RtE, 1'b1));
        brstall = BranchD &&
                  (match(RsD, WriteRegE, RegWriteE) || match(RtD, WriteRegE, RegWriteE) ||
                   match(RsD, WriteRegM, MemtoRegM) || match(RtD, WriteRegM, MemtoRegM));
        rawstall = 1'b0;
        if (FWD_EN == 0) begin
            rawstall = match(RsD, WriteRegE, RegWriteE) || match(RtD, WriteRegE, RegWriteE) ||
                       match(RsD, WriteRegM, RegWriteM) || match(RtD, WriteRegM, RegWriteM);
        end
        mdstall = MDUseD && (MDStartE || (md_cnt_q != '0));
        stall   = lwstall || brstall || rawstall || mdstall;
    end

    // Output decode; reset forces a bubble into E and suppresses stalls and forwards.
    always_comb begin
        StallF    = stall;
        StallD    = stall;
        FlushE    = stall;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (FWD_EN != 0) begin
            ForwardAD = match(RsD, WriteRegM, RegWriteM);
            ForwardBD = match(RtD, WriteRegM, RegWriteM);
            if (match(RsE, WriteRegM, RegWriteM))      ForwardAE = 2'b10;
            else if (match(RsE, WriteRegW, RegWriteW)) ForwardAE = 2'b01;
            if (match(RtE, WriteRegM, RegWriteM))      ForwardBE = 2'b10;
            else if (match(RtE, WriteRegW, RegWriteW)) ForwardBE = 2'b01;
        end
        MDBusy = (md_cnt_q != '0);
        if (reset) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            FlushE    = 1'b1;
            ForwardAD = 1'b0;
            ForwardBD = 1'b0;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            MDBusy    = 1'b0;
        end
    end

    // Mult/div countdown and saturating stall counter next-state.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (MDStartE) begin
            md_cnt_d = MdReload;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
        stall_cnt_d = stall_cnt_q;
        if (StallD && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously even mid mult/div.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: a forwarding instance (default parameters) and a
// stall-only instance with a narrow stall counter share the same stimulus.
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       reset;
    logic       BranchD, MDUseD, MemtoRegE, RegWriteE, MDStartE;
    logic       MemtoRegM, RegWriteM, RegWriteW;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;

    logic        f_stall_f, f_stall_d, f_flush_e, f_fwd_ad, f_fwd_bd, f_md_busy;
    logic [1:0]  f_fwd_ae, f_fwd_be;
    logic [15:0] f_stall_cnt;
    logic        n_stall_f, n_stall_d, n_flush_e, n_fwd_ad, n_fwd_bd, n_md_busy;
    logic [1:0]  n_fwd_ae, n_fwd_be;
    logic [3:0]  n_stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int stalls;

    always #5 clk = ~clk;

    hazard_unit_mc u_fwd (
        .clk(clk), .reset(reset), .BranchD(BranchD), .MDUseD(MDUseD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MDStartE(MDStartE),
        .WriteRegE(WriteRegE), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .StallF(f_stall_f), .StallD(f_stall_d), .FlushE(f_flush_e),
        .ForwardAD(f_fwd_ad), .ForwardBD(f_fwd_bd), .ForwardAE(f_fwd_ae),
        .ForwardBE(f_fwd_be), .MDBusy(f_md_busy), .StallCnt(f_stall_cnt)
    );

    hazard_unit_mc #(.REG_W(5), .MD_LAT(4), .FWD_EN(0), .CNT_W(4)) u_nofwd (
        .clk(clk), .reset(reset), .BranchD(BranchD), .MDUseD(MDUseD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE), .MDStartE(MDStartE),
        .WriteRegE(WriteRegE), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
        .StallF(n_stall_f), .StallD(n_stall_d), .FlushE(n_flush_e),
        .ForwardAD(n_fwd_ad), .ForwardBD(n_fwd_bd), .ForwardAE(n_fwd_ae),
        .ForwardBE(n_fwd_be), .MDBusy(n_md_busy), .StallCnt(n_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        BranchD = 0; MDUseD = 0; MemtoRegE = 0; RegWriteE = 0; MDStartE = 0;
        MemtoRegM = 0; RegWriteM = 0; RegWriteW = 0;
        RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        clr_inputs();
        reset = 1'b1;
        // Hazard present during reset must be masked.
        MemtoRegE = 1; RtE = 6; RsD = 6;
        RsE = 6; WriteRegM = 6; RegWriteM = 1;
        #2;
        chk("rst_stalld", f_stall_d, 0);
        chk("rst_stallf", f_stall_f, 0);
        chk("rst_flushe", f_flush_e, 1);
        chk("rst_fwdae", f_fwd_ae, 0);
        chk("rst_fwdad", f_fwd_ad, 0);
        chk("rst_mdbusy", f_md_busy, 0);
        chk("rst_cnt", f_stall_cnt, 0);
        tick();
        do_reset();

        // 1: E-stage forwarding priority
        RsE = 6; WriteRegM = 6; RegWriteM = 1; WriteRegW = 6; RegWriteW = 1; #1;
        chk("t1_ae_m", f_fwd_ae, 2'b10);
        chk("t1_ae_nofwd", n_fwd_ae, 2'b00);
        chk("t1_nostall", f_stall_d, 0);
        RegWriteM = 0; #1;
        chk("t1_ae_w", f_fwd_ae, 2'b01);
        RsE = 0; #1;
        chk("t1_ae_zero", f_fwd_ae, 2'b00);
        RtE = 6; RegWriteM = 1; #1;
        chk("t1_be_m", f_fwd_be, 2'b10);

        // 2: load-use stall
        do_reset();
        MemtoRegE = 1; RtE = 6; RsD = 6; #1;
        chk("t2_stallf", f_stall_f, 1);
        chk("t2_stalld", f_stall_d, 1);
        chk("t2_flushe", f_flush_e, 1);
        tick(); tick(); tick();
        chk("t2_cnt3", f_stall_cnt, 3);
        chk("t2_cnt3_nofwd", n_stall_cnt, 3);
        MemtoRegE = 0; #1;
        chk("t2_release", f_stall_d, 0);
        tick();
        chk("t2_cnt_hold", f_stall_cnt, 3);

        // 3: branch comparator hazards
        do_reset();
        BranchD = 1; RegWriteE = 1; WriteRegE = 5; RsD = 5; #1;
        chk("t3_br_e", f_stall_d, 1);
        RegWriteE = 0; WriteRegM = 5; MemtoRegM = 1; #1;
        chk("t3_br_mload", f_stall_d, 1);
        MemtoRegM = 0; RegWriteM = 1; #1;
        chk("t3_br_fwd_ad", f_fwd_ad, 1);
        chk("t3_br_nostall", f_stall_d, 0);
        chk("t3_nofwd_stall", n_stall_d, 1);
        chk("t3_nofwd_ad", n_fwd_ad, 0);

        // 4: mult/div interlock lasts MD_LAT cycles
        do_reset();
        MDUseD = 1; MDStartE = 1; #1;
        chk("t4_start_stall", f_stall_d, 1);
        chk("t4_start_busy", f_md_busy, 0);
        tick();
        MDStartE = 0; #1;
        stalls = 1;
        for (int i = 1; i <= 3; i++) begin
            chk($sformatf("t4_busy%0d", i), f_md_busy, 1);
            chk($sformatf("t4_stall%0d", i), f_stall_d, 1);
            stalls += int'(f_stall_d);
            tick();
        end
        chk("t4_busy_done", f_md_busy, 0);
        chk("t4_stall_done", f_stall_d, 0);
        chk("t4_stall_total", stalls, 4);
        chk("t4_cnt", f_stall_cnt, 4);

        // 5: stall-only mode
        do_reset();
        RegWriteM = 1; WriteRegM = 7; RtD = 7; RtE = 7; #1;
        chk("t5_nofwd_stall", n_stall_d, 1);
        chk("t5_nofwd_bd", n_fwd_bd, 0);
        chk("t5_nofwd_be", n_fwd_be, 2'b00);
        chk("t5_fwd_nostall", f_stall_d, 0);
        chk("t5_fwd_bd", f_fwd_bd, 1);
        chk("t5_fwd_be", f_fwd_be, 2'b10);
        RegWriteM = 0; RegWriteW = 1; WriteRegW = 7; #1;
        chk("t5_w_nostall", n_stall_d, 0);
        chk("t5_w_be", f_fwd_be, 2'b01);

        // 6: async reset mid mult/div, then saturation
        do_reset();
        MDUseD = 1; MDStartE = 1;
        tick();
        MDStartE = 0;
        tick();
        chk("t6_pre_busy", f_md_busy, 1);
        chk("t6_pre_cnt", f_stall_cnt, 2);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_busy", f_md_busy, 0);
        chk("t6_rst_cnt", f_stall_cnt, 0);
        chk("t6_rst_flush", f_flush_e, 1);
        chk("t6_rst_stall", f_stall_d, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_resume_busy", f_md_busy, 0);
        chk("t6_resume_stall", f_stall_d, 0);
        MDUseD = 0; MemtoRegE = 1; RtE = 6; RsD = 6;
        for (int i = 0; i < 19; i++) tick();
        chk("t6_sat_nofwd", n_stall_cnt, 4'hF);
        chk("t6_fwd_cnt19", f_stall_cnt, 19);
        tick();
        chk("t6_sat_hold", n_stall_cnt, 4'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
